alu_sec_nbits: RTL and testbench

ALU_SEC_NBITS -- requirements
Module: alu_sec_nbits

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb_nbits.sv | 52 +++++
 rtl/alu_sec_nbits.sv | 132 +++++++++++++
 tb/tb_alu_sec_nbits.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants and FSM state encoding shared by the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_comb_nbits.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb_nbits
// Description : Single-cycle logic/arithmetic datapath with carry and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb_nbits
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_op,
    output logic [N-1:0] o_result,
    output logic         o_carry,
    output logic         o_ovf
);

    logic         w_sub;
    logic [N-1:0] w_b_eff;
    logic [N:0]   w_sum;
    logic         w_c_msb;
    logic         w_ovf;

    // SLT reuses the subtractor so the sign test can be overflow-corrected
    assign w_sub   = (i_op == OP_SUB) || (i_op == OP_SLT);
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_sub};
    assign w_c_msb = i_a[N-1] ^ w_b_eff[N-1] ^ w_sum[N-1];
    assign w_ovf   = w_c_msb ^ w_sum[N];

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        o_ovf    = 1'b0;
        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_NOR: o_result = ~(i_a | i_b);
            OP_ADD, OP_SUB: begin
                o_result = w_sum[N-1:0];
                o_carry  = w_sum[N];
                o_ovf    = w_ovf;
            end
            OP_SLT: o_result = {{(N-1){1'b0}}, w_sum[N-1] ^ w_ovf};
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_sec_nbits.sv
`default_nettype none
// ============================================================================
// Module      : alu_sec_nbits
// Description : Handshaked ALU with multi-cycle shift-add MUL and bit-serial shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sec_nbits
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic [3:0]     operacion_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [N-1:0]   resultado_o,
    output logic           c_o,
    output logic           zero_o,
    output logic           ovf_o
);

    localparam logic [SHW:0] c_MUL_STEPS = (SHW + 1)'(N);

    state_t         r_state;
    logic [3:0]     r_op;
    logic [N-1:0]   r_opa;
    logic [N-1:0]   r_opb;
    logic [N-1:0]   r_res;
    logic           r_c;
    logic           r_ovf;
    logic [SHW:0]   r_cnt;

    logic [N-1:0]   w_comb_res;
    logic           w_comb_c;
    logic           w_comb_ovf;
    logic [SHW-1:0] w_shamt;

    assign w_shamt = b_i[SHW-1:0];

    alu_comb_nbits #(
        .N (N)
    ) u_comb (
        .i_a      (a_i),
        .i_b      (b_i),
        .i_op     (operacion_i),
        .o_result (w_comb_res),
        .o_carry  (w_comb_c),
        .o_ovf    (w_comb_ovf)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        r_op  <= operacion_i;
                        r_opa <= a_i;
                        r_opb <= b_i;
                        r_c   <= 1'b0;
                        r_ovf <= 1'b0;
                        case (operacion_i)
                            OP_MUL: begin
                                r_res   <= '0;
                                r_cnt   <= c_MUL_STEPS;
                                r_state <= ST_EXEC;
                            end
                            OP_SLL, OP_SRL: begin
                                r_res   <= a_i;
                                r_cnt   <= {1'b0, w_shamt};
                                r_state <= (w_shamt == '0) ? ST_DONE : ST_EXEC;
                            end
                            default: begin
                                r_res   <= w_comb_res;
                                r_c     <= w_comb_c;
                                r_ovf   <= w_comb_ovf;
                                r_state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    // r_res doubles as the accumulator / shift register while busy
                    r_cnt <= r_cnt - 1'b1;
                    if (r_op == OP_MUL) begin
                        if (r_opb[0]) begin
                            r_res <= r_res + r_opa;
                        end
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                    end else if (r_op == OP_SLL) begin
                        r_res <= r_res << 1;
                    end else begin
                        r_res <= r_res >> 1;
                    end
                    if (r_cnt == {{SHW{1'b0}}, 1'b1}) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready_o     = (r_state == ST_IDLE);
    assign valid_o     = (r_state == ST_DONE);
    assign resultado_o = r_res;
    assign c_o         = r_c;
    assign ovf_o       = r_ovf;
    assign zero_o      = (r_res == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_sec_nbits.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sec_nbits
// Description : Scoreboard bench for alu_sec_nbits (N=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sec_nbits;

    localparam int N = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [N-1:0]  a_i;
    logic [N-1:0]  b_i;
    logic [3:0]    operacion_i;
    logic          valid_o;
    logic          ready_i;
    logic [N-1:0]  resultado_o;
    logic          c_o;
    logic          zero_o;
    logic          ovf_o;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        ovf;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    alu_sec_nbits #(.N(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .operacion_i (operacion_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .resultado_o (resultado_o),
        .c_o         (c_o),
        .zero_o      (zero_o),
        .ovf_o       (ovf_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        e = '0;
        e.lat = 8'd1;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[31:0];
                e.c   = s[32];
                e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.res = s[31:0];
                e.c   = s[32];
                e.ovf = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin
                e.res = a * b;
                e.lat = 8'd33;
            end
            4'b1001: begin
                e.res = a << b[4:0];
                e.lat = 8'(b[4:0]) + 8'd1;
            end
            4'b1010: begin
                e.res = a >> b[4:0];
                e.lat = 8'(b[4:0]) + 8'd1;
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Issue one op, scramble inputs while busy, then check result, flags and latency.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        exp_t        e;
        int          lat;
        logic [31:0] snap;
        check_eq("ready_before_issue", ready_o, 1);
        operacion_i = op;
        a_i         = a;
        b_i         = b;
        valid_i     = 1'b1;
        ready_i     = (hold == 0);
        sb.push_back(model(op, a, b));
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i     = 1'b0;
        a_i         = $urandom;
        b_i         = $urandom;
        operacion_i = 4'($urandom);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(negedge clk_i);
            a_i = $urandom;
            b_i = $urandom;
            lat++;
        end
        check_eq("valid_seen", valid_o, 1);
        e = sb.pop_front();
        check_eq($sformatf("res op%b", op), resultado_o, e.res);
        check_eq($sformatf("carry op%b", op), c_o, e.c);
        check_eq($sformatf("zero op%b", op), zero_o, e.z);
        check_eq($sformatf("ovf op%b", op), ovf_o, e.ovf);
        check_eq($sformatf("latency op%b", op), lat, e.lat);
        if (hold > 0) begin
            snap = resultado_o;
            for (int i = 0; i < hold; i++) begin
                a_i = $urandom;
                b_i = $urandom;
                @(negedge clk_i);
                check_eq("hold_res", resultado_o, snap);
                check_eq("hold_valid", valid_o, 1);
                check_eq("hold_ready", ready_o, 0);
            end
            ready_i = 1'b1;
        end
        @(negedge clk_i);
        check_eq("idle_after_handoff_ready", ready_o, 1);
        check_eq("idle_after_handoff_valid", valid_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; operacion_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_res", resultado_o, 0);
        check_eq("rst_zero", zero_o, 1);
        check_eq("rst_c", c_o, 0);
        check_eq("rst_ovf", ovf_o, 0);

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
        run_op(4'b0110, 32'd5, 32'd5, 0);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        run_op(4'b1000, 32'h0001_0003, 32'h5, 0);
        run_op(4'b1001, 32'h1, 32'd31, 0);
        run_op(4'b1010, 32'hDEAD_BEEF, 32'h100, 0);
        run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run_op(4'b0001, 32'hF000_0001, 32'h0000_1230, 0);
        run_op(4'b1100, 32'hF000_0001, 32'h0000_1230, 0);
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(4'b0110, 32'h8000_0000, 32'h1, 0);
        run_op(4'b0011, 32'h1234_5678, 32'h1, 0);
        run_op(4'b1010, 32'h8000_0000, 32'd4, 10);
        for (int k = 0; k < 6; k++) begin
            logic [3:0] ops [6];
            ops = '{4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};
            run_op(ops[k], $urandom, 32'($urandom_range(0, 40)), 0);
        end

        // Abort a MUL with reset five cycles in.
        operacion_i = 4'b1000; a_i = 32'd7; b_i = 32'd9; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_eq("abort_ready", ready_o, 1);
        check_eq("abort_res", resultado_o, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen++;
            @(negedge clk_i);
        end
        check_eq("abort_no_valid", seen, 0);
        run_op(4'b0010, 32'd2, 32'd3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
